// File: rtl/adc_sched_pkg.sv
// Shared types and defaults for the MCP3201 conversion scheduler.
// Optional result averaging is enabled by defining ADC_AVG_EN.
package adc_sched_pkg;

    localparam int ADC_W       = 12;
    localparam int TIMEOUT_DEF = 63;
    localparam int GAP_DEF     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        CAPTURE = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/adc_tick_gen.sv
// Periodic sample tick generator; period changes are applied at wrap,
// and the counter is held at zero while sampling is disabled.
module adc_tick_gen
    import adc_sched_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                adcclk,
    input  logic                adcrst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] per_r;
    logic                wrap;

    assign wrap = enable && (per_r != '0) && (cnt == per_r - ONE);
    assign tick = wrap;

    // per_r is the period in force; it only reloads at a wrap or while idle
    always_ff @(posedge adcclk or negedge adcrst_n) begin
        if (!adcrst_n) begin
            cnt   <= '0;
            per_r <= '0;
        end else if (!enable || per_r == '0 || wrap) begin
            cnt   <= '0;
            per_r <= period;
        end else begin
            cnt   <= cnt + ONE;
        end
    end

endmodule

// File: rtl/adc_sample_sched.sv
// MCP3201 conversion scheduler: request pacing, start/done handshake,
// timeout and recovery gap. Define ADC_AVG_EN for grouped averaging.
module adc_sample_sched
    import adc_sched_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int GAP      = GAP_DEF,
    parameter int AVG_LOG2 = 2
) (
    input  logic                adcclk,
    input  logic                adcrst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                single,
    input  logic                err_clr,
    output logic                adcdav,
    input  logic                davadc,
    input  logic [ADC_W-1:0]    adc0data,
    output logic [ADC_W-1:0]    sample,
    output logic                sample_vld,
    output logic                busy,
    output logic                timeout_err,
    output logic                overrun
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 2);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_C   = GW'(GAP);

    state_t        state;
    state_t        state_n;
    logic          tick;
    logic          pending;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic          go_start;
    logic          cap;
    logic          tmo;
    logic          rel_done;

    adc_tick_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tick (
        .adcclk   (adcclk),
        .adcrst_n (adcrst_n),
        .enable   (enable),
        .period   (period),
        .tick     (tick)
    );

    assign go_start = (state == IDLE) && pending;
    assign cap      = (state == START) && davadc;
    assign tmo      = (state == START) && !davadc && (tcnt == TO_LAST);
    assign rel_done = (state == RELEASE) && !davadc && (gcnt >= GAP_C);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (pending) state_n = START;
            START: begin
                if (davadc)   state_n = CAPTURE;
                else if (tmo) state_n = RELEASE;
            end
            CAPTURE: state_n = RELEASE;
            RELEASE: if (rel_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // adcdav and busy are registered from the next state so they stay glitch-free
    always_ff @(posedge adcclk or negedge adcrst_n) begin
        if (!adcrst_n) begin
            state       <= IDLE;
            adcdav      <= 1'b0;
            busy        <= 1'b0;
            pending     <= 1'b0;
            tcnt        <= '0;
            gcnt        <= '0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            adcdav      <= (state_n == START) || (state_n == CAPTURE);
            busy        <= (state_n != IDLE);
            pending     <= (pending && !go_start) || ((tick || single) && !pending);
            timeout_err <= tmo || (timeout_err && !err_clr);
            overrun     <= (tick && pending) || (overrun && !err_clr);
            if (state != START) tcnt <= '0;
            else                tcnt <= tcnt + TW'(1);
            if (state != RELEASE)  gcnt <= '0;
            else if (gcnt < GAP_C) gcnt <= gcnt + GW'(1);
        end
    end

`ifdef ADC_AVG_EN
    localparam int AW = ADC_W + AVG_LOG2;

    logic [AW-1:0]       acc;
    logic [AW-1:0]       sum;
    logic [AVG_LOG2-1:0] grp;
    logic                en_q;

    assign sum = acc + AW'(adc0data);

    always_ff @(posedge adcclk or negedge adcrst_n) begin
        if (!adcrst_n) begin
            acc        <= '0;
            grp        <= '0;
            en_q       <= 1'b0;
            sample     <= '0;
            sample_vld <= 1'b0;
        end else begin
            en_q       <= enable;
            sample_vld <= 1'b0;
            if (en_q && !enable) begin
                acc <= '0;
                grp <= '0;
            end else if (cap) begin
                if (&grp) begin
                    sample     <= sum[AW-1:AVG_LOG2];
                    sample_vld <= 1'b1;
                    acc        <= '0;
                    grp        <= '0;
                end else begin
                    acc <= sum;
                    grp <= grp + AVG_LOG2'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge adcclk or negedge adcrst_n) begin
        if (!adcrst_n) begin
            sample     <= '0;
            sample_vld <= 1'b0;
        end else begin
            sample_vld <= cap;
            if (cap) sample <= adc0data;
        end
    end
`endif

endmodule

// File: tb/tb_adc_sample_sched.sv
// Directed bench for adc_sample_sched with a behavioural MCP3201 reader.
// The averaging scenario is compiled only when ADC_AVG_EN is defined.
module tb_adc_sample_sched;

    logic        adcclk = 1'b0;
    logic        adcrst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] period = '0;
    logic        single = 1'b0;
    logic        err_clr = 1'b0;
    logic        adcdav;
    logic        davadc = 1'b0;
    logic [11:0] adc0data = '0;
    logic [11:0] sample;
    logic        sample_vld;
    logic        busy;
    logic        timeout_err;
    logic        overrun;

    int          n_checks = 0;
    int          n_fail = 0;

    logic        hang = 1'b0;
    logic [11:0] rd_data = '0;
    int          rcnt = 0;

    always #5 adcclk = ~adcclk;

    adc_sample_sched dut (
        .adcclk      (adcclk),
        .adcrst_n    (adcrst_n),
        .enable      (enable),
        .period      (period),
        .single      (single),
        .err_clr     (err_clr),
        .adcdav      (adcdav),
        .davadc      (davadc),
        .adc0data    (adc0data),
        .sample      (sample),
        .sample_vld  (sample_vld),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    // reader: finishes 37 cycles after start, holds done until start drops
    always @(negedge adcclk) begin
        if (!adcdav) begin
            davadc = 1'b0;
            rcnt   = 0;
        end else if (!hang && !davadc) begin
            if (rcnt == 36) begin
                davadc   = 1'b1;
                adc0data = rd_data;
            end else begin
                rcnt++;
            end
        end
    end

    task automatic pulse_single;
        @(negedge adcclk) single = 1'b1;
        @(negedge adcclk) single = 1'b0;
    endtask

    task automatic pulse_err_clr;
        @(negedge adcclk) err_clr = 1'b1;
        @(negedge adcclk) err_clr = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge adcclk);
        n_checks++;
        if ({adcdav, sample_vld, busy, timeout_err, overrun, sample} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b %b %b %b %b %h, want all 0",
                     adcdav, sample_vld, busy, timeout_err, overrun, sample);
        end
        adcrst_n = 1'b1;
        repeat (5) @(negedge adcclk);
        n_checks++;
        if ({adcdav, busy, sample_vld} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got adcdav=%b busy=%b vld=%b, want 0 0 0",
                     adcdav, busy, sample_vld);
        end
    endtask

    task automatic test_single;
        int ok;
        int nv;
        rd_data = 12'hA5C;
        @(negedge adcclk) single = 1'b1;
        @(negedge adcclk) single = 1'b0;
        n_checks++;
        if (adcdav !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pending: adcdav=%b, want 0", adcdav);
        end
        @(negedge adcclk);
        n_checks++;
        if (adcdav !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start: adcdav=%b busy=%b, want 1 1", adcdav, busy);
        end
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge adcclk);
            if (davadc) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (ok == 0) begin
            n_fail++;
            $display("FAIL single_done_wait: davadc never rose, want 1");
        end
        #1;
        n_checks++;
        if (sample_vld !== 1'b1 || sample !== 12'hA5C) begin
            n_fail++;
            $display("FAIL single_capture: vld=%b sample=%h, want 1 a5c", sample_vld, sample);
        end
        @(posedge adcclk) #1;
        n_checks++;
        if (sample_vld !== 1'b0 || adcdav !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_release: vld=%b adcdav=%b busy=%b, want 0 0 1",
                     sample_vld, adcdav, busy);
        end
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge adcclk);
            if (sample_vld) nv++;
        end
        n_checks++;
        if (busy !== 1'b0 || nv != 0 || sample !== 12'hA5C) begin
            n_fail++;
            $display("FAIL single_after: busy=%b extra_vld=%0d sample=%h, want 0 0 a5c",
                     busy, nv, sample);
        end
    endtask

    task automatic test_periodic;
        int t[$];
        int bad;
        rd_data = 12'h123;
        @(negedge adcclk) period = 16'd100;
        repeat (3) @(negedge adcclk);
        enable = 1'b1;
        for (int i = 1; i <= 1300; i++) begin
            @(negedge adcclk);
            if (i == 1000) enable = 1'b0;
            if (sample_vld) t.push_back(i);
        end
        n_checks++;
        if (t.size() != 10) begin
            n_fail++;
            $display("FAIL periodic_count: got %0d pulses, want 10", t.size());
        end
        bad = 0;
        for (int k = 1; k < t.size(); k++)
            if (t[k] - t[k-1] != 100) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL periodic_spacing: %0d bad gaps, want 0", bad);
        end
        n_checks++;
        if (overrun !== 1'b0 || sample !== 12'h123) begin
            n_fail++;
            $display("FAIL periodic_flags: overrun=%b sample=%h, want 0 123", overrun, sample);
        end
    endtask

    task automatic test_overrun;
        int rises;
        int nv;
        int lowrun;
        int short_gaps;
        logic prev;
        rises = 0;
        nv = 0;
        lowrun = 100;
        short_gaps = 0;
        prev = 1'b0;
        rd_data = 12'h0F0;
        @(negedge adcclk) period = 16'd20;
        repeat (3) @(negedge adcclk);
        enable = 1'b1;
        for (int i = 1; i <= 550; i++) begin
            @(negedge adcclk);
            if (i == 400) enable = 1'b0;
            if (adcdav && !prev) begin
                rises++;
                if (lowrun < 2) short_gaps++;
            end
            if (!adcdav) lowrun++;
            else         lowrun = 0;
            prev = adcdav;
            if (sample_vld) nv++;
        end
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_flag: overrun=%b, want 1", overrun);
        end
        n_checks++;
        if (rises < 2 || rises != nv) begin
            n_fail++;
            $display("FAIL overrun_one_in_flight: starts=%0d samples=%0d, want equal and >=2",
                     rises, nv);
        end
        n_checks++;
        if (short_gaps != 0) begin
            n_fail++;
            $display("FAIL overrun_gap: %0d short low gaps, want 0", short_gaps);
        end
        pulse_err_clr();
        n_checks++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: overrun=%b busy=%b, want 0 0", overrun, busy);
        end
    endtask

    task automatic test_timeout;
        int hi;
        int nv;
        hi = 0;
        nv = 0;
        hang = 1'b1;
        pulse_single();
        for (int i = 0; i < 120; i++) begin
            @(negedge adcclk);
            if (adcdav) hi++;
            if (sample_vld) nv++;
        end
        n_checks++;
        if (hi != 63) begin
            n_fail++;
            $display("FAIL timeout_len: adcdav high %0d cycles, want 63", hi);
        end
        n_checks++;
        if (timeout_err !== 1'b1 || nv != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flag: err=%b vld_count=%0d busy=%b, want 1 0 0",
                     timeout_err, nv, busy);
        end
        hang = 1'b0;
        pulse_err_clr();
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: err=%b, want 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid;
        int ok;
        int nv;
        rd_data = 12'h3C1;
        pulse_single();
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge adcclk);
            if (adcdav) begin
                ok = 1;
                break;
            end
        end
        repeat (5) @(negedge adcclk);
        #2 adcrst_n = 1'b0;
        #1;
        n_checks++;
        if (ok == 0 || {adcdav, sample_vld, busy, timeout_err, overrun, sample} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid: started=%0d adcdav=%b busy=%b sample=%h, want 1 0 0 000",
                     ok, adcdav, busy, sample);
        end
        repeat (2) @(negedge adcclk);
        adcrst_n = 1'b1;
        repeat (3) @(negedge adcclk);
        pulse_single();
        nv = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge adcclk);
            if (sample_vld) nv++;
        end
        n_checks++;
        if (nv != 1 || sample !== 12'h3C1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resume: pulses=%0d sample=%h busy=%b, want 1 3c1 0",
                     nv, sample, busy);
        end
    endtask

`ifdef ADC_AVG_EN
    task automatic test_avg;
        int nv;
        nv = 0;
        for (int k = 0; k < 4; k++) begin
            rd_data = 12'(100 + k);
            pulse_single();
            for (int i = 0; i < 60; i++) begin
                @(negedge adcclk);
                if (sample_vld) nv++;
            end
        end
        n_checks++;
        if (nv != 1 || sample !== 12'd101) begin
            n_fail++;
            $display("FAIL avg_result: pulses=%0d sample=%0d, want 1 101", nv, sample);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef ADC_AVG_EN
        test_avg();
`else
        test_single();
        test_periodic();
        test_overrun();
        test_timeout();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
